pre_emphasis_filter: RTL and testbench

//   First MFCC front-end stage: y[n] = x[n] - alpha*x[n-1] (Q15 alpha) on 16-bit signed PCM.

---
 rtl/mfcc_pkg.sv | 33 +++
 rtl/q15_mul_round.sv | 27 ++
 rtl/pre_emphasis_filter.sv | 154 +++++++++++++++
 tb/tb_pre_emphasis_filter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mfcc_pkg.sv
// Shared constants and saturation helpers for the MFCC front-end pipeline stages.
package mfcc_pkg;

    localparam logic [15:0]        Q15_ONE       = 16'h7FFF;
    localparam logic signed [32:0] Q15_ROUND     = 33'sd16384;
    localparam logic [15:0]        ALPHA_DEFAULT = 16'h7C29;
    localparam logic [15:0]        DC_POLE       = 16'h7F5C;

    typedef enum logic [1:0] {
        SAT_NONE = 2'd0,
        SAT_HIGH = 2'd1,
        SAT_LOW  = 2'd2
    } sat_kind_e;

    function automatic sat_kind_e sat_kind(input logic signed [17:0] v);
        if (v > 18'sd32767) begin
            sat_kind = SAT_HIGH;
        end else if (v < -18'sd32768) begin
            sat_kind = SAT_LOW;
        end else begin
            sat_kind = SAT_NONE;
        end
    endfunction

    function automatic logic signed [15:0] sat16(input logic signed [17:0] v);
        case (sat_kind(v))
            SAT_HIGH: sat16 = 16'sh7FFF;
            SAT_LOW:  sat16 = 16'sh8000;
            default:  sat16 = v[15:0];
        endcase
    endfunction

endpackage

// File: rtl/q15_mul_round.sv
// Signed sample times unsigned Q15 coefficient; product registered, rounded half-up on the way out.
module q15_mul_round
    import mfcc_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic signed [15:0] a_i,
    input  logic [15:0]        coef_i,
    output logic signed [17:0] q_o
);

    logic signed [32:0] p_d;
    logic signed [32:0] p_q;

    assign p_d = a_i * $signed({1'b0, coef_i});
    assign q_o = 18'((p_q + Q15_ROUND) >>> 15);

    // Product register; the rounding shift is taken from the registered value.
    always_ff @(posedge clk) begin
        if (rst) begin
            p_q <= 33'sd0;
        end else begin
            p_q <= p_d;
        end
    end

endmodule

// File: rtl/pre_emphasis_filter.sv
// Pre-emphasis y[n] = x[n] - alpha*x[n-1] with rounding, saturation and clip counting.
// Optional DC-blocker front stage enabled by defining PREEMPH_DC_BLOCK_EN.
module pre_emphasis_filter #(
    parameter int          DATA_W        = 16,
`ifdef PREEMPH_DC_BLOCK_EN
    parameter logic [15:0] DC_POLE       = mfcc_pkg::DC_POLE,
`endif
    parameter logic [15:0] ALPHA_DEFAULT = mfcc_pkg::ALPHA_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] audio_in,
    input  logic              audio_valid,
    input  logic              clear,
    input  logic [15:0]       cfg_alpha,
    input  logic              cfg_alpha_we,
    output logic [DATA_W-1:0] preemph_out,
    output logic              preemph_valid,
    output logic [15:0]       sat_count
);
    import mfcc_pkg::*;

    logic signed [15:0] x_s;
    logic               v_s;
    logic [15:0]        alpha_q, alpha_d;
    logic signed [15:0] xprev_q, xprev_d;
    logic signed [15:0] x1_q, x1_d;
    logic               v1_q, v1_d;
    logic signed [17:0] q1_s;
    logic signed [17:0] d_s;
    logic [15:0]        out_q, out_d;
    logic               vout_q, vout_d;
    logic [15:0]        sat_q, sat_d;

`ifdef PREEMPH_DC_BLOCK_EN
    logic signed [15:0] x0prev_q, x0prev_d;
    logic signed [15:0] h_q, h_d;
    logic               v0_q;
    logic signed [17:0] q0_s;
    logic signed [17:0] sum0_s;

    // The multiplier is fed h_d so its registered product always matches h_q.
    q15_mul_round u_dc_mul (
        .clk    (clk),
        .rst    (rst),
        .a_i    (h_d),
        .coef_i (DC_POLE),
        .q_o    (q0_s)
    );

    // DC-blocker next state: h[n] = x[n] - x[n-1] + R*h[n-1].
    always_comb begin
        sum0_s = $signed({{2{audio_in[15]}}, audio_in})
               - $signed({{2{x0prev_q[15]}}, x0prev_q}) + q0_s;
        if (clear) begin
            h_d      = 16'sd0;
            x0prev_d = 16'sd0;
        end else if (audio_valid) begin
            h_d      = sat16(sum0_s);
            x0prev_d = $signed(audio_in);
        end else begin
            h_d      = h_q;
            x0prev_d = x0prev_q;
        end
    end

    // DC-blocker state and stage valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_q      <= 16'sd0;
            x0prev_q <= 16'sd0;
            v0_q     <= 1'b0;
        end else begin
            h_q      <= h_d;
            x0prev_q <= x0prev_d;
            v0_q     <= audio_valid & ~clear;
        end
    end

    assign x_s = h_q;
    assign v_s = v0_q;
`else
    assign x_s = $signed(audio_in);
    assign v_s = audio_valid;
`endif

    q15_mul_round u_pe_mul (
        .clk    (clk),
        .rst    (rst),
        .a_i    (xprev_q),
        .coef_i (alpha_q),
        .q_o    (q1_s)
    );

    assign d_s = $signed({{2{x1_q[15]}}, x1_q}) - q1_s;

    // Next-state for alpha, history, valid pipe, output and clip counter.
    always_comb begin
        alpha_d = alpha_q;
        if (cfg_alpha_we) begin
            alpha_d = cfg_alpha[15] ? Q15_ONE : cfg_alpha;
        end else begin
            alpha_d = alpha_q;
        end
        if (clear) begin
            xprev_d = 16'sd0;
        end else if (v_s) begin
            xprev_d = x_s;
        end else begin
            xprev_d = xprev_q;
        end
        v1_d   = v_s & ~clear;
        x1_d   = v1_d ? x_s : x1_q;
        vout_d = v1_q & ~clear;
        out_d  = out_q;
        sat_d  = sat_q;
        if (vout_d) begin
            out_d = sat16(d_s);
            if (sat_kind(d_s) != SAT_NONE && sat_q != 16'hFFFF) begin
                sat_d = sat_q + 16'd1;
            end else begin
                sat_d = sat_q;
            end
        end else begin
            out_d = out_q;
        end
    end

    // Pipeline and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            alpha_q <= ALPHA_DEFAULT;
            xprev_q <= 16'sd0;
            x1_q    <= 16'sd0;
            v1_q    <= 1'b0;
            out_q   <= 16'd0;
            vout_q  <= 1'b0;
            sat_q   <= 16'd0;
        end else begin
            alpha_q <= alpha_d;
            xprev_q <= xprev_d;
            x1_q    <= x1_d;
            v1_q    <= v1_d;
            out_q   <= out_d;
            vout_q  <= vout_d;
            sat_q   <= sat_d;
        end
    end

    assign preemph_out   = out_q;
    assign preemph_valid = vout_q;
    assign sat_count     = sat_q;

endmodule

// File: tb/tb_pre_emphasis_filter.sv
// Scoreboard bench for pre_emphasis_filter; follows PREEMPH_DC_BLOCK_EN for latency and model.
module tb_pre_emphasis_filter;

`ifdef PREEMPH_DC_BLOCK_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] audio_in;
    logic        audio_valid;
    logic        clear;
    logic [15:0] cfg_alpha;
    logic        cfg_alpha_we;
    logic [15:0] preemph_out;
    logic        preemph_valid;
    logic [15:0] sat_count;

    pre_emphasis_filter dut (
        .clk           (clk),
        .rst           (rst),
        .audio_in      (audio_in),
        .audio_valid   (audio_valid),
        .clear         (clear),
        .cfg_alpha     (cfg_alpha),
        .cfg_alpha_we  (cfg_alpha_we),
        .preemph_out   (preemph_out),
        .preemph_valid (preemph_valid),
        .sat_count     (sat_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int t;
        int y;
        int sat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_out = 0;
    bit   flush_pending = 1'b0;
    int   m_prev, m_alpha, m_sat, m_x0, m_h;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int rnd_q15(input int a, input int c);
        longint p;
        p = longint'(a) * longint'(c);
        return int'((p + 64'sd16384) >>> 15);
    endfunction

    function automatic int clamp16(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    task automatic model_reset();
        m_prev  = 0;
        m_alpha = 32'h7C29;
        m_sat   = 0;
        m_x0    = 0;
        m_h     = 0;
    endtask

    // One input cycle; pushes the expected output (model or literal) when a sample is accepted.
    task automatic step(input bit v, input int x, input bit clr, input bit we, input int a,
                        input bit lit_en, input int lit);
        int xs, d, y;
        @(posedge clk);
        #1;
        if (flush_pending) begin
            sb.delete();
            flush_pending = 1'b0;
        end
        audio_valid  = v;
        audio_in     = 16'(x);
        clear        = clr;
        cfg_alpha_we = we;
        cfg_alpha    = 16'(a);
        if (clr) begin
            m_prev = 0;
            m_x0   = 0;
            m_h    = 0;
            flush_pending = 1'b1;
        end else if (v) begin
            xs = x;
`ifdef PREEMPH_DC_BLOCK_EN
            xs   = clamp16(x - m_x0 + rnd_q15(m_h, 32'h7F5C));
            m_x0 = x;
            m_h  = xs;
`endif
            d = xs - rnd_q15(m_prev, m_alpha);
            y = clamp16(d);
            if (y != d && m_sat < 65535) m_sat = m_sat + 1;
            m_prev = xs;
            sb.push_back('{t: cyc + LAT, y: (lit_en ? lit : y), sat: m_sat});
        end
        if (we) m_alpha = a[15] ? 32'h7FFF : (a & 32'hFFFF);
    endtask

    task automatic samp(input int x);
        step(1'b1, x, 1'b0, 1'b0, 0, 1'b0, 0);
    endtask

    task automatic samp_lit(input int x, input int lit);
        step(1'b1, x, 1'b0, 1'b0, 0, 1'b1, lit);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, 1'b0, 0, 1'b0, 0);
    endtask

    task automatic do_clear(input bit v, input int x);
        step(v, x, 1'b1, 1'b0, 0, 1'b0, 0);
    endtask

    // Scoreboard consumer: every output pulse must match the head entry in value, timing and count.
    always @(negedge clk) begin
        if (!rst && preemph_valid) begin
            if (sb.size() == 0) begin
                check_eq("unexpected_valid", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                last_out = int'($signed(preemph_out));
                check_eq("latency", cyc, e.t);
                check_eq("out", last_out, e.y);
                check_eq("sat_count", int'(sat_count), e.sat);
            end
        end
    end

    task automatic apply_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        audio_valid = 1'b0;
        clear = 1'b0;
        cfg_alpha_we = 1'b0;
        sb.delete();
        flush_pending = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_out", int'(preemph_out), 0);
        check_eq("rst_valid", int'(preemph_valid), 0);
        check_eq("rst_sat", int'(sat_count), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [15:0] r;
        logic [7:0]  pat;
        rst = 1'b1;
        audio_in = 16'd0;
        audio_valid = 1'b0;
        clear = 1'b0;
        cfg_alpha = 16'd0;
        cfg_alpha_we = 1'b0;
        model_reset();
        apply_reset();

`ifndef PREEMPH_DC_BLOCK_EN
        // Impulse with default alpha.
        samp_lit(1000, 1000);
        samp_lit(0, -970);
        samp_lit(0, 0);
        idle(4);
        // Clear drops the in-flight sample and zeroes history.
        samp_lit(500, 500);
        samp_lit(500, 15);
        samp(500);
        do_clear(1'b0, 0);
        idle(1);
        samp_lit(500, 500);
        do_clear(1'b1, 1234);
        samp_lit(100, 100);
        // Alpha write: same-cycle sample still uses the old alpha; bit15 maps to 0x7FFF.
        step(1'b1, 1000, 1'b0, 1'b1, 32'hFFFF, 1'b1, 903);
        samp_lit(0, -1000);
        idle(4);
        // Saturation at full-scale step.
        do_clear(1'b0, 0);
        samp_lit(-32768, -32768);
        samp_lit(32767, 32767);
        idle(4);
        check_eq("sat_after_step", int'(sat_count), 1);
`else
        // DC blocker: a constant input settles close to zero.
        for (int i = 0; i < 2000; i++) samp(1000);
        idle(LAT + 2);
        check_eq("dc_settled", int'(last_out < 8 && last_out > -8), 1);
`endif

        // Gapped stream: output pattern follows input pattern after the fixed latency.
        pat = 8'b11001011;
        for (int i = 0; i < 8; i++) begin
            r = 16'($urandom);
            step(pat[i], int'($signed(r)), 1'b0, 1'b0, 0, 1'b0, 0);
        end
        idle(LAT + 2);

        // Random stream with occasional alpha writes and clears.
        for (int i = 0; i < 60; i++) begin
            r = 16'($urandom);
            if ($urandom_range(0, 15) == 0) begin
                do_clear(1'($urandom_range(0, 1)), int'($signed(r)));
            end else begin
                step(1'($urandom_range(0, 3) != 0), int'($signed(r)), 1'b0,
                     1'($urandom_range(0, 7) == 0), int'($urandom_range(0, 65535)), 1'b0, 0);
            end
        end
        idle(LAT + 2);

        // Mid-stream reset loses in-flight samples and restores alpha.
        samp(1111);
        samp(-2222);
        apply_reset();
        samp(1000);
        samp(0);
        idle(LAT + 2);

        // Clip counter sticks at 0xFFFF.
        samp(32767);
        for (int i = 0; i < 65540; i++) samp((i % 2 == 0) ? -32768 : 32767);
        idle(LAT + 2);
        check_eq("sat_sticky", int'(sat_count), 65535);
        check_eq("drain", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
